// File: rtl/depth_estimator_pkg.sv
// Shared parameter header for the depth estimator.
// Holds the legacy peak-detector constants (Nb, peakMax), the default
// parameter values of depth_estimator and the state encodings of the
// top-level FSM and of the divide/multiply datapath.
package depth_estimator_pkg;

  // Peak-detector bin index width and largest bin index.
  localparam int Nb      = 8;
  localparam int peakMax = (1 << Nb) - 1;

  // Defaults for depth_estimator.
  localparam int          NB_DEF       = Nb;
  localparam int          FH_LOG2_DEF  = 4;
  localparam int          AVG_LOG2_DEF = 2;
  localparam int unsigned BIN_MM_DEF   = 15;

  // Top-level FSM: accumulate frames, run the arithmetic, present the result.
  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_MUL = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  // Phases of the sequential divide/multiply datapath.
  typedef enum logic [1:0] {
    AR_IDLE = 2'd0,
    AR_DIV  = 2'd1,
    AR_MUL  = 2'd2,
    AR_DONE = 2'd3
  } arith_phase_t;

endpackage

// File: rtl/depth_estimator_if.sv
// Peak-in / depth-out bundle of the depth estimator.
//   master : peak-detector / consumer side (drives peak*, depthReady)
//   slave  : depth estimator side (drives depthMm, depthValid, noTarget, overrun)
interface depth_estimator_if #(
  parameter int NB = 8
);
  logic          peakValid;
  logic [NB-1:0] peakCH;
  logic [NB-1:0] peakFH;
  logic [23:0]   depthMm;
  logic          depthValid;
  logic          depthReady;
  logic          noTarget;
  logic          overrun;

  modport master (
    output peakValid, peakCH, peakFH, depthReady,
    input  depthMm, depthValid, noTarget, overrun
  );

  modport slave (
    input  peakValid, peakCH, peakFH, depthReady,
    output depthMm, depthValid, noTarget, overrun
  );
endinterface

// File: rtl/depth_estimator_arith.sv
// depth_arith: sequential mean and scale datapath.
// On start it captures the window sum and hit count, forms
// mean = sum / hits (shift when hits is a power of two, otherwise a
// BW-step restoring divider; zero when hits is zero), then multiplies the
// mean by BIN_MM with an 8-step shift-add multiplier and halves the product.
// Ports:
//   clk, resN      : clock, synchronous active-low reset
//   start          : one-cycle request, sum/hits sampled with it
//   sum [AW]       : accumulated bin sum
//   hits [CW]      : number of hit frames
//   done           : one-cycle pulse, result valid in the same cycle
//   result [24]    : mean * BIN_MM / 2, truncated
module depth_arith
  import depth_estimator_pkg::*;
#(
  parameter int          BW     = 12,
  parameter int          AW     = 14,
  parameter int          CW     = 3,
  parameter int unsigned BIN_MM = 15
) (
  input  logic          clk,
  input  logic          resN,
  input  logic          start,
  input  logic [AW-1:0] sum,
  input  logic [CW-1:0] hits,
  output logic          done,
  output logic [23:0]   result
);

  localparam int PW   = BW + 8;
  localparam int SMAX = (BW > 8) ? BW : 8;
  localparam int SW   = $clog2(SMAX);

  arith_phase_t  phase_reg;
  logic [SW-1:0] step_reg;
  logic [CW-1:0] rem_reg;
  logic [CW-1:0] divisor_reg;
  logic [BW-1:0] dq_reg;       // dividend bits shift out the top, quotient bits shift in
  logic [PW-1:0] mcand_reg;
  logic [PW-1:0] prod_reg;
  logic [7:0]    mplier_reg;
  logic          done_reg;

  logic [CW:0]   trial;
  logic          q_bit;
  logic [CW-1:0] rem_next;
  logic          hits_pow2;
  logic [7:0]    shamt;

  always_comb begin
    trial     = {rem_reg, dq_reg[BW-1]};
    q_bit     = (trial >= {1'b0, divisor_reg});
    rem_next  = q_bit ? CW'(trial - {1'b0, divisor_reg}) : trial[CW-1:0];
    hits_pow2 = ((hits & (hits - CW'(1))) == '0);
    shamt     = '0;
    for (int i = 0; i < CW; i++) begin
      if (hits[i]) shamt = 8'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resN) begin
      phase_reg   <= AR_IDLE;
      step_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      dq_reg      <= '0;
      mcand_reg   <= '0;
      prod_reg    <= '0;
      mplier_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (phase_reg)
        AR_IDLE: begin
          if (start) begin
            step_reg   <= '0;
            prod_reg   <= '0;
            mplier_reg <= 8'(BIN_MM);
            if (hits == '0) begin
              mcand_reg <= '0;
              phase_reg <= AR_MUL;
            end else if (hits_pow2) begin
              mcand_reg <= PW'(sum >> shamt);
              phase_reg <= AR_MUL;
            end else begin
              // sum < hits * 2^BW, so the upper bits alone are already
              // smaller than the divisor and BW steps yield the quotient.
              rem_reg     <= CW'(sum[AW-1:BW]);
              dq_reg      <= sum[BW-1:0];
              divisor_reg <= hits;
              phase_reg   <= AR_DIV;
            end
          end
        end
        AR_DIV: begin
          rem_reg <= rem_next;
          dq_reg  <= {dq_reg[BW-2:0], q_bit};
          if (step_reg == SW'(BW - 1)) begin
            step_reg  <= '0;
            mcand_reg <= PW'({dq_reg[BW-2:0], q_bit});
            phase_reg <= AR_MUL;
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end
        AR_MUL: begin
          if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (step_reg == SW'(7)) begin
            step_reg  <= '0;
            done_reg  <= 1'b1;
            phase_reg <= AR_DONE;
          end else begin
            step_reg <= step_reg + SW'(1);
          end
        end
        AR_DONE: phase_reg <= AR_IDLE;
        default: phase_reg <= AR_IDLE;
      endcase
    end
  end

  assign done   = done_reg;
  assign result = 24'(prod_reg >> 1);

endmodule

// File: rtl/depth_estimator.sv
// depth_estimator: averages peak-detector results over 2^AVG_LOG2 frames
// and reports the mean round-trip distance in mm.
// Ports:
//   clk   : clock, rising edge
//   resN  : synchronous active-low reset
//   bus   : depth_estimator_if.slave
//           peakValid/peakCH/peakFH in, depthMm/depthValid/noTarget out,
//           depthReady in, overrun out (sticky until reset)
module depth_estimator
  import depth_estimator_pkg::*;
#(
  parameter int          NB       = NB_DEF,
  parameter int          FH_LOG2  = FH_LOG2_DEF,
  parameter int          AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned BIN_MM   = BIN_MM_DEF
) (
  input  logic               clk,
  input  logic               resN,
  depth_estimator_if.slave   bus
);

  localparam int BW = NB + FH_LOG2;     // fine-bin index width
  localparam int AW = BW + AVG_LOG2;    // holds 2^AVG_LOG2 maximum bins
  localparam int CW = AVG_LOG2 + 1;     // hit count 0 .. 2^AVG_LOG2
  localparam logic [NB-1:0] FH_MAX = NB'((1 << FH_LOG2) - 1);

  state_t              state_reg, state_next;
  logic [AW-1:0]       acc_reg, acc_next;
  logic [CW-1:0]       hit_cnt_reg, hit_cnt_next;
  logic [AVG_LOG2-1:0] frame_cnt_reg;
  logic [23:0]         depth_reg;
  logic                no_target_reg;
  logic                overrun_reg;

  logic                accept, is_hit, last_frame;
  logic                arith_start, arith_done;
  logic [23:0]         arith_result;
  logic                depth_valid, handshake;
  logic [NB-1:0]       ch_m1, fh_m1;
  logic [FH_LOG2-1:0]  fh_clip;
  logic [BW-1:0]       bin;

  // State register.
  always_ff @(posedge clk) begin
    if (!resN) state_reg <= ST_ACC;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_ACC:  if (last_frame) state_next = ST_MUL;
      ST_MUL:  if (arith_done) state_next = ST_OUT;
      ST_OUT:  if (bus.depthReady) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // FSM outputs and frame decode.
  always_comb begin
    accept     = (state_reg == ST_ACC) && bus.peakValid;
    is_hit     = (bus.peakCH != '0) && (bus.peakFH != '0);
    last_frame = accept && (frame_cnt_reg == '1);
    ch_m1      = bus.peakCH - NB'(1);
    fh_m1      = bus.peakFH - NB'(1);
    fh_clip    = (fh_m1 > FH_MAX) ? FH_LOG2'(FH_MAX) : fh_m1[FH_LOG2-1:0];
    // (CH-1)*2^FH_LOG2 + clipped fine offset is just a concatenation.
    bin          = {ch_m1, fh_clip};
    acc_next     = acc_reg + (is_hit ? AW'(bin) : '0);
    hit_cnt_next = hit_cnt_reg + (is_hit ? CW'(1) : '0);
    // The arithmetic sees the totals including the closing frame.
    arith_start  = last_frame;
    depth_valid  = (state_reg == ST_OUT);
    handshake    = depth_valid && bus.depthReady;
  end

  // Window accumulation, result capture and overrun flag.
  always_ff @(posedge clk) begin
    if (!resN) begin
      acc_reg       <= '0;
      hit_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      depth_reg     <= '0;
      no_target_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (accept) begin
        frame_cnt_reg <= frame_cnt_reg + AVG_LOG2'(1);
        if (is_hit) begin
          acc_reg     <= acc_next;
          hit_cnt_reg <= hit_cnt_next;
        end
      end
      if ((state_reg == ST_MUL) && arith_done) begin
        depth_reg     <= arith_result;
        no_target_reg <= (hit_cnt_reg == '0);
      end
      if (handshake) begin
        acc_reg       <= '0;
        hit_cnt_reg   <= '0;
        frame_cnt_reg <= '0;
      end
      // Includes the OUT->ACC cycle, since the state is still OUT then.
      if (bus.peakValid && (state_reg != ST_ACC)) overrun_reg <= 1'b1;
    end
  end

  depth_arith #(
    .BW     (BW),
    .AW     (AW),
    .CW     (CW),
    .BIN_MM (BIN_MM)
  ) u_arith (
    .clk    (clk),
    .resN   (resN),
    .start  (arith_start),
    .sum    (acc_next),
    .hits   (hit_cnt_next),
    .done   (arith_done),
    .result (arith_result)
  );

  assign bus.depthMm    = depth_reg;
  assign bus.depthValid = depth_valid;
  assign bus.noTarget   = no_target_reg;
  assign bus.overrun    = overrun_reg;

endmodule

// File: doc/depth_estimator.md
DEPTH_ESTIMATOR -- requirements
Module: depth_estimator

Interface
REQ-001 SHALL have parameter NB, default 8, width of the coarse (CH) and fine (FH) peak-bin indices.
REQ-002 SHALL have parameter FH_LOG2, default 4, log2 of the number of fine bins per coarse bin.
REQ-003 SHALL have parameter AVG_LOG2, default 2, log2 of the number of frames averaged per result (4).
REQ-004 SHALL have parameter BIN_MM, default 15, distance of one fine bin in mm (unsigned, 8 bits).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port resN, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port peakValid, input, 1 bit, one-cycle strobe marking a frame result from the peak detector.
REQ-008 SHALL have port peakCH, input, NB bits, coarse peak bin; value 0 means no peak, since bins start at 1.
REQ-009 SHALL have port peakFH, input, NB bits, fine peak bin; value 0 means no peak.
REQ-010 SHALL have port depthMm, output, 24 bits, averaged distance in mm.
REQ-011 SHALL have port depthValid, output, 1 bit, result available.
REQ-012 SHALL have port depthReady, input, 1 bit, consumer accepts the result.
REQ-013 SHALL have port noTarget, output, 1 bit, qualifies depthValid: no frame in the window had a peak.
REQ-014 SHALL have port overrun, output, 1 bit, sticky; a peakValid arrived while the block was not in ACC.

Function
REQ-015 SHALL implement FSM states ACC, MUL and OUT.
REQ-016 In ACC, each peakValid SHALL increment frameCnt, an AVG_LOG2-bit counter that wraps.
REQ-017 A frame SHALL be a hit when peakCH≠0 and peakFH≠0, otherwise a miss.
REQ-018 On a hit, bin = (peakCH−1)·2^FH_LOG2 + min(peakFH−1, 2^FH_LOG2−1) SHALL be added to acc, and hitCnt SHALL be incremented.
REQ-019 acc SHALL be sized to hold 2^AVG_LOG2 maximum bins without overflow.
REQ-020 When frameCnt wraps, i.e. the 2^AVG_LOG2-th peakValid is accepted, the FSM SHALL go to MUL on the next cycle.
REQ-021 mean SHALL be the accumulated sum including that last frame, divided by hitCnt (including that frame).
  - hitCnt equal to a power of two: divide by shift.
  - otherwise: truncating division by a sequential restoring divider.
  - hitCnt = 0: mean = 0 and noTarget = 1.
REQ-022 MUL SHALL compute depthMm = mean·BIN_MM/2 (round-trip halved, truncated) using an 8-cycle shift-add multiplier, after any divider cycles.
REQ-023 Latency from the accepting peakValid to depthValid SHALL be at most 8 + (NB+FH_LOG2) + 2 cycles.
REQ-024 In OUT, depthValid SHALL be 1 and depthMm/noTarget SHALL hold stable until the cycle in which depthReady = 1.
REQ-025 On that depthReady cycle the FSM SHALL return to ACC with acc, hitCnt and frameCnt cleared.
REQ-026 If depthReady is already 1 when OUT is entered, the transfer SHALL complete in that first OUT cycle.
REQ-027 A peakValid in MUL or OUT SHALL be dropped and SHALL set overrun.
REQ-028 A peakValid in the same cycle as the OUT→ACC transition SHALL also be dropped.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 While resN = 0 at a clock edge, the FSM SHALL go to ACC.
REQ-031 Reset SHALL clear acc, hitCnt, frameCnt, the divider and the multiplier.
REQ-032 Reset SHALL set depthMm = 0, depthValid = 0, noTarget = 0 and overrun = 0.
REQ-033 Reset mid-MUL or mid-OUT SHALL abandon the result with no depthValid pulse.
REQ-034 The first peakValid accepted SHALL be the one sampled with resN = 1 in the cycle after release.

Structure
REQ-035 NB, FH_LOG2, AVG_LOG2, BIN_MM defaults and the FSM state encodings SHALL live in the shared SiFH parameter header, alongside the existing Nb/peakMax.
REQ-036 The sequential divide/multiply datapath SHALL be one sub-module, depth_arith, with start/done handshake.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
  - Four frames CH=3, FH=5, depthReady=1 → one depthValid; mean = 2·16+4 = 36; depthMm = 270; noTarget = 0.
  - Frames (CH,FH) = (1,1), (1,3), (0,0), (2,1) → hitCnt = 3; sum = 0+2+16 = 18; mean = 6; depthMm = 45.
  - Four frames all CH=0 → depthValid with noTarget = 1 and depthMm = 0.
  - depthReady held 0 for 20 cycles while peakValid pulses → depthMm stable, overrun = 1, the next window starts empty after the handshake.
  - FH=40 (above 16) with CH=1 on all frames → clipped bin 15; depthMm = 112.
  - resN = 0 during MUL → no depthValid; the next four CH=2, FH=1 frames → depthMm = 120.
